dht11_responder: RTL
====================

Name: dht11_responder

Overview:
- Synthesizable DHT11 sensor emulator: the responder end of the single-wire protocol that the DHT11 host controller initiates.
- Watches the open-drain transmission line for a host start pulse, then answers with the DHT11 acknowledge sequence and a 40-bit frame: humidity int/dec, temperature int/dec, checksum.
- Used on-board and in benches as a stand-in sensor, so the sensor-connection path and the UART path can be exercised without hardware.

Parameters:
- TICKS_PER_US, 50, clock cycles per microsecond (50 MHz board clock).
- START_MIN_US, 18000, minimum host low time accepted as a start request.
- RESP_WAIT_US, 30, delay after host release before the acknowledge begins.
- ACK_US, 80, duration of each acknowledge phase (low, then high).
- BIT_LOW_US, 50, low preamble before each data bit and the end-of-frame low.
- BIT0_HIGH_US, 27, released (high) time encoding a 0.
- BIT1_HIGH_US, 70, released (high) time encoding a 1.

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  responder armed; 0 = ignore line and keep it released.
- hum_int  input  8  humidity integer byte.
- hum_dec  input  8  humidity decimal byte.
- temp_int  input  8  temperature integer byte.
- temp_dec  input  8  temperature decimal byte.
- corrupt_checksum  input  1  when 1 at frame latch, transmitted checksum is inverted.
- transmission_line  inout  1  open-drain line: driven 0 or high-Z, never driven 1.
- busy  output  1  high from start detection until frame end or abort.
- frame_done  output  1  one-cycle pulse after the end-of-frame low is released.
- collision  output  1  one-cycle pulse on abort due to line contention.

Behaviour:
- Clock and reset: one clock `clock`; reset is asynchronous and active-low on `reset_n`.
- Reset state: internal drive_low=0 (line released), busy=0, frame_done=0, collision=0, state=IDLE, all counters=0. Line is released immediately on reset assertion, including mid-frame.
- Line input: passes through a 2-FF synchronizer; the FSM sees the result 2 cycles late. All timing counts cycles of the synchronized value.
- Time unit: all durations are X_US*TICKS_PER_US cycles, counted by one timer register. The timer is wide enough for START_MIN_US*TICKS_PER_US and saturates; it never wraps.
- IDLE: line released. When enable=1 and the synced line is 0, clear the timer and go to HOST_LOW.
- HOST_LOW: count cycles while the line stays 0.
  - Line returns to 1 with count >= START_MIN → latch the four data bytes, go to RESP_WAIT, set busy=1.
  - Line returns to 1 earlier → glitch; back to IDLE, no output activity.
- Frame latch: checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256, bitwise inverted if corrupt_checksum=1. The frame is shifted MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum. Input changes after the latch do not affect the frame in flight.
- Phase sequence:
  - RESP_WAIT (released, RESP_WAIT_US)
  - ACK_LOW (drive 0, ACK_US)
  - ACK_HIGH (released, ACK_US)
  - then per bit: BIT_LOW (drive 0, BIT_LOW_US) → BIT_HIGH (released, BIT0_HIGH_US or BIT1_HIGH_US)
  - after bit 39: END_LOW (drive 0, BIT_LOW_US) → release, pulse frame_done, busy=0, go to IDLE.
- Bit counter: 6 bits, 0..39, increments on leaving BIT_HIGH.
- Collision: in any released phase after RESP_WAIT (ACK_HIGH, BIT_HIGH), synced line = 0 → release, pulse collision, busy=0, IDLE. Blind window: the first 2 cycles of each released phase are not checked (synchronizer latency).
- enable falling mid-frame: abort at the next clock edge; line released, busy=0, no frame_done, no collision pulse.
- Idle re-arm: the line must be seen high in IDLE for at least 1 cycle before a new start is accepted. Back-to-back frames are otherwise allowed.
- Never drive 1 on the line; the tristate is `drive_low ? 1'b0 : 1'bz`.

Test Plan:
- Bench overrides: TICKS_PER_US=1, START_MIN_US=100; other parameters at default.
- Valid frame, normal data: hum 0x37/0x00, temp 0x19/0x00 (55%, 25 C), host low 120 cycles then release → ack 80 low/80 high, 40 bits decode to 0x37,0x00,0x19,0x00,0x50; frame_done pulses once; busy high throughout.
- Short start pulse: host low 60 cycles → line never driven by responder, busy stays 0.
- Corrupt checksum: corrupt_checksum=1 with the bytes above → checksum byte 0xAF; the DHT11 host controller flags the checksum error, so the path response is 0x45/0x45.
- Contention: host forces the line low 10 cycles into bit 5's high phase → collision pulses once, line released, busy=0, state returns to IDLE; next valid start yields a full frame.
- Aborts: enable dropped during ACK_LOW → line released the next cycle, no frame_done. reset_n asserted during bit 20 → line high-Z immediately, all outputs 0.
- Checksum wrap: hum_int 0xFF, hum_dec 0x02, temp 0x00/0x00 → checksum 0x01; a 1-bit decodes as a 70-cycle high, a 0-bit as 27 cycles.

Source files
------------

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: detects a host start pulse on the open-drain line and
// answers with the acknowledge sequence followed by a 40-bit humidity/temperature frame.
`timescale 1ns/1ps
module dht11_responder #(
   parameter int TICKS_PER_US = 50,
   parameter int START_MIN_US = 18000,
   parameter int RESP_WAIT_US = 30,
   parameter int ACK_US       = 80,
   parameter int BIT_LOW_US   = 50,
   parameter int BIT0_HIGH_US = 27,
   parameter int BIT1_HIGH_US = 70
)(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [7:0] hum_int,
   input  logic [7:0] hum_dec,
   input  logic [7:0] temp_int,
   input  logic [7:0] temp_dec,
   input  logic       corrupt_checksum,
   inout  wire        transmission_line,
   output logic       busy,
   output logic       frame_done,
   output logic       collision
);

   localparam int START_TICKS = START_MIN_US * TICKS_PER_US;
   localparam int RESP_TICKS  = RESP_WAIT_US * TICKS_PER_US;
   localparam int ACK_TICKS   = ACK_US       * TICKS_PER_US;
   localparam int BLOW_TICKS  = BIT_LOW_US   * TICKS_PER_US;
   localparam int B0_TICKS    = BIT0_HIGH_US * TICKS_PER_US;
   localparam int B1_TICKS    = BIT1_HIGH_US * TICKS_PER_US;
   localparam int MAX_A       = (START_TICKS > RESP_TICKS) ? START_TICKS : RESP_TICKS;
   localparam int MAX_B       = (ACK_TICKS > BLOW_TICKS) ? ACK_TICKS : BLOW_TICKS;
   localparam int MAX_C       = (B0_TICKS > B1_TICKS) ? B0_TICKS : B1_TICKS;
   localparam int MAX_AB      = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_TICKS   = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
   localparam int TIMER_W     = $clog2(MAX_TICKS + 1);

   typedef logic [TIMER_W-1:0] timer_t;

   localparam timer_t START_LIM  = timer_t'(START_TICKS);
   localparam timer_t RESP_LAST  = timer_t'(RESP_TICKS - 1);
   localparam timer_t ACK_LAST   = timer_t'(ACK_TICKS - 1);
   localparam timer_t BLOW_LAST  = timer_t'(BLOW_TICKS - 1);
   localparam timer_t B0_LAST    = timer_t'(B0_TICKS - 1);
   localparam timer_t B1_LAST    = timer_t'(B1_TICKS - 1);
   localparam timer_t BLIND_END  = timer_t'(2);
   localparam timer_t TIMER_SAT  = {TIMER_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE, ST_HOST_LOW, ST_RESP_WAIT, ST_ACK_LOW,
      ST_ACK_HIGH, ST_BIT_LOW, ST_BIT_HIGH, ST_END_LOW
   } state_t;

   function automatic logic [7:0] calc_checksum(
      input logic [7:0] a, input logic [7:0] b,
      input logic [7:0] c, input logic [7:0] d, input logic invert);
      logic [7:0] sum;
      sum = a + b + c + d;
      return invert ? ~sum : sum;
   endfunction

   state_t      state_r, state_next_s;
   timer_t      timer_r;
   logic [39:0] frame_r;
   logic [5:0]  bit_cnt_r;
   logic        line_meta_r, line_sync_r, armed_r;
   logic        drive_low_r, busy_r, frame_done_r, collision_r;
   logic        latch_s, shift_s, done_s, coll_s;
   timer_t      bit_last_s;

   assign transmission_line = drive_low_r ? 1'b0 : 1'bz;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;
   assign collision  = collision_r;

   // Two-stage synchronizer for the shared line; idles high like the pulled-up bus.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         line_meta_r <= 1'b1;
         line_sync_r <= 1'b1;
      end else begin
         line_meta_r <= transmission_line;
         line_sync_r <= line_meta_r;
      end
   end

   // Phase sequencing, contention and enable-abort decisions.
   always_comb begin
      state_next_s = state_r;
      latch_s      = 1'b0;
      shift_s      = 1'b0;
      done_s       = 1'b0;
      coll_s       = 1'b0;
      bit_last_s   = frame_r[39] ? B1_LAST : B0_LAST;
      if ((state_r != ST_IDLE) && !enable) begin
         state_next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (enable && armed_r && !line_sync_r) state_next_s = ST_HOST_LOW;
               else                                   state_next_s = ST_IDLE;
            end
            ST_HOST_LOW: begin
               if (line_sync_r) begin
                  if (timer_r >= START_LIM) begin
                     state_next_s = ST_RESP_WAIT;
                     latch_s      = 1'b1;
                  end else begin
                     state_next_s = ST_IDLE;
                  end
               end else begin
                  state_next_s = ST_HOST_LOW;
               end
            end
            ST_RESP_WAIT: begin
               if (timer_r == RESP_LAST) state_next_s = ST_ACK_LOW;
               else                      state_next_s = ST_RESP_WAIT;
            end
            ST_ACK_LOW: begin
               if (timer_r == ACK_LAST) state_next_s = ST_ACK_HIGH;
               else                     state_next_s = ST_ACK_LOW;
            end
            ST_ACK_HIGH: begin
               if ((timer_r >= BLIND_END) && !line_sync_r) begin
                  state_next_s = ST_IDLE;
                  coll_s       = 1'b1;
               end else if (timer_r == ACK_LAST) begin
                  state_next_s = ST_BIT_LOW;
               end else begin
                  state_next_s = ST_ACK_HIGH;
               end
            end
            ST_BIT_LOW: begin
               if (timer_r == BLOW_LAST) state_next_s = ST_BIT_HIGH;
               else                      state_next_s = ST_BIT_LOW;
            end
            ST_BIT_HIGH: begin
               if ((timer_r >= BLIND_END) && !line_sync_r) begin
                  state_next_s = ST_IDLE;
                  coll_s       = 1'b1;
               end else if (timer_r == bit_last_s) begin
                  shift_s = 1'b1;
                  if (bit_cnt_r == 6'd39) state_next_s = ST_END_LOW;
                  else                    state_next_s = ST_BIT_LOW;
               end else begin
                  state_next_s = ST_BIT_HIGH;
               end
            end
            ST_END_LOW: begin
               if (timer_r == BLOW_LAST) begin
                  state_next_s = ST_IDLE;
                  done_s       = 1'b1;
               end else begin
                  state_next_s = ST_END_LOW;
               end
            end
            default: state_next_s = ST_IDLE;
         endcase
      end
   end

   // State register and the shared saturating phase timer (cleared on every phase change).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         timer_r <= '0;
         armed_r <= 1'b0;
      end else begin
         state_r <= state_next_s;
         if (state_next_s != state_r) timer_r <= '0;
         else if (timer_r != TIMER_SAT) timer_r <= timer_r + timer_t'(1);
         else timer_r <= timer_r;
         armed_r <= (state_r == ST_IDLE) && line_sync_r;
      end
   end

   // Frame capture at start acceptance, then MSB-first shifting with a bit counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frame_r   <= 40'd0;
         bit_cnt_r <= 6'd0;
      end else if (latch_s) begin
         frame_r   <= {hum_int, hum_dec, temp_int, temp_dec,
                       calc_checksum(hum_int, hum_dec, temp_int, temp_dec, corrupt_checksum)};
         bit_cnt_r <= 6'd0;
      end else if (shift_s) begin
         frame_r   <= {frame_r[38:0], 1'b0};
         bit_cnt_r <= bit_cnt_r + 6'd1;
      end
   end

   // Registered line drive and status outputs, derived from the upcoming phase.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         drive_low_r  <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         collision_r  <= 1'b0;
      end else begin
         drive_low_r  <= (state_next_s == ST_ACK_LOW) || (state_next_s == ST_BIT_LOW) ||
                         (state_next_s == ST_END_LOW);
         busy_r       <= (state_next_s != ST_IDLE) && (state_next_s != ST_HOST_LOW);
         frame_done_r <= done_s;
         collision_r  <= coll_s;
      end
   end

endmodule
